// File: rtl/sc_eval_scheduler_if.sv
// Request, datapath and response signals of the stochastic evaluation scheduler.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface sc_eval_scheduler_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op;
   logic [17:0] req_a;
   logic [17:0] req_b;
   logic [8:0]  dp_input_1;
   logic [8:0]  dp_input_2;
   logic [1:0]  dp_op_sel;
   logic        sn_mul;
   logic        sn_add;
   logic        sn_smul;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [8:0]  rsp_data;
   logic        busy;
   logic        window_tick;

   modport slave (
      input  req_valid, req_op, req_a, req_b, sn_mul, sn_add, sn_smul, rsp_ready,
      output req_ready, dp_input_1, dp_input_2, dp_op_sel, rsp_valid, rsp_id,
             rsp_data, busy, window_tick
   );

   modport master (
      output req_valid, req_op, req_a, req_b, sn_mul, sn_add, sn_smul, rsp_ready,
      input  req_ready, dp_input_1, dp_input_2, dp_op_sel, rsp_valid, rsp_id,
             rsp_data, busy, window_tick
   );
endinterface

// File: rtl/sc_eval_scheduler.sv
// Time-shares one stochastic add/multiply datapath between two requesters:
// round-robin accept, settle, count SN ones over a 2^WIN_LOG2 window, respond.
module sc_eval_scheduler #(
   parameter int WIN_LOG2 = 17,
   parameter int SETTLE   = 2
) (
   input logic            clk,
   input logic            rst_n,
   sc_eval_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [WIN_LOG2-1:0] C_RUN_LAST    = {WIN_LOG2{1'b1}};
   localparam logic [WIN_LOG2-1:0] C_RUN_PRE     = {{(WIN_LOG2-1){1'b1}}, 1'b0};
   localparam logic [WIN_LOG2-1:0] C_SETTLE_LAST = WIN_LOG2'(SETTLE - 1);
   localparam logic [WIN_LOG2:0]   C_FULL        = {1'b1, {WIN_LOG2{1'b0}}};

   state_t              r_state;
   logic [WIN_LOG2-1:0] r_cyc;
   logic [WIN_LOG2:0]   r_ones;
   logic [8:0]          r_a;
   logic [8:0]          r_b;
   logic [1:0]          r_op;
   logic                r_id;
   logic                r_last;
   logic                r_rsp_valid;
   logic                r_rsp_id;
   logic [8:0]          r_rsp_data;
   logic                r_busy;
   logic                r_tick;

   state_t              w_next_state;
   logic [1:0]          w_grant;
   logic                w_accept;
   logic                w_win_id;
   logic [1:0]          w_win_op;
   logic [8:0]          w_win_a;
   logic [8:0]          w_win_b;
   logic                w_sn_bit;
   logic [WIN_LOG2:0]   w_ones_final;
   logic [8:0]          w_result;
   logic                w_tick_next;
   logic                w_hs;

   assign w_accept = |w_grant;
   assign w_win_id = w_grant[1];
   assign w_win_op = w_win_id ? bus.req_op[3:2] : bus.req_op[1:0];
   assign w_win_a  = w_win_id ? bus.req_a[17:9] : bus.req_a[8:0];
   assign w_win_b  = w_win_id ? bus.req_b[17:9] : bus.req_b[8:0];
   assign w_hs     = r_rsp_valid & bus.rsp_ready;

   // Round-robin arbitration: one-hot grant in IDLE, the non-last requester wins a tie.
   always_comb begin
      w_grant = 2'b00;
      if (r_state == ST_IDLE) begin
         case (bus.req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
         endcase
      end else begin
         w_grant = 2'b00;
      end
   end

   // Select the SN bit of the latched op and form the saturated 9-bit average.
   always_comb begin
      w_sn_bit = 1'b0;
      case (r_op)
         2'd0:    w_sn_bit = bus.sn_mul;
         2'd1:    w_sn_bit = bus.sn_add;
         2'd2:    w_sn_bit = bus.sn_smul;
         default: w_sn_bit = 1'b0;
      endcase
      w_ones_final = r_ones + {{WIN_LOG2{1'b0}}, w_sn_bit};
      if (w_ones_final == C_FULL) begin
         w_result = 9'h1FF;
      end else begin
         w_result = w_ones_final[WIN_LOG2-1 -: 9];
      end
   end

   // Next-state logic; the window tick is registered one cycle ahead of the last RUN cycle.
   always_comb begin
      w_next_state = r_state;
      w_tick_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = (w_win_op == 2'd3) ? ST_RESP : ST_SETTLE;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (r_cyc == C_SETTLE_LAST) begin
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_SETTLE;
            end
         end
         ST_RUN: begin
            w_tick_next = (r_cyc == C_RUN_PRE);
            if (r_cyc == C_RUN_LAST) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         ST_RESP: begin
            if (w_hs) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RESP;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register, operand latch, window counters and response registers.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state     <= ST_IDLE;
         r_cyc       <= '0;
         r_ones      <= '0;
         r_a         <= 9'd0;
         r_b         <= 9'd0;
         r_op        <= 2'd0;
         r_id        <= 1'b0;
         r_last      <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= 9'd0;
         r_busy      <= 1'b0;
         r_tick      <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != ST_IDLE);
         r_tick  <= w_tick_next;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a    <= w_win_a;
                  r_b    <= w_win_b;
                  r_op   <= w_win_op;
                  r_id   <= w_win_id;
                  r_last <= w_win_id;
                  r_cyc  <= '0;
                  r_ones <= '0;
                  if (w_win_op == 2'd3) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_id    <= w_win_id;
                     r_rsp_data  <= 9'd0;
                  end
               end
            end
            ST_SETTLE: begin
               r_cyc <= (r_cyc == C_SETTLE_LAST) ? '0 : r_cyc + WIN_LOG2'(1);
            end
            ST_RUN: begin
               r_ones <= w_ones_final;
               r_cyc  <= r_cyc + WIN_LOG2'(1);
               if (r_cyc == C_RUN_LAST) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_id    <= r_id;
                  r_rsp_data  <= w_result;
               end
            end
            ST_RESP: begin
               if (w_hs) begin
                  r_rsp_valid <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = w_grant;
   assign bus.dp_input_1  = r_a;
   assign bus.dp_input_2  = r_b;
   assign bus.dp_op_sel   = r_op;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_id      = r_rsp_id;
   assign bus.rsp_data    = r_rsp_data;
   assign bus.busy        = r_busy;
   assign bus.window_tick = r_tick;

endmodule

// File: tb/tb_sc_eval_scheduler.sv
// Randomized bench for sc_eval_scheduler with a job-level reference model:
// expected grant, timing and averaged result are computed from the requester
// queue, the SN bits the bench drove, and plain arithmetic.
module tb_sc_eval_scheduler;
   localparam int W      = 10;
   localparam int S      = 2;
   localparam int RUNLEN = 1 << W;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sc_eval_scheduler_if bus ();

   sc_eval_scheduler #(.WIN_LOG2(W), .SETTLE(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Requester model: pending job per requester and the last granted id.
   logic       pv  [2];
   logic [1:0] pop [2];
   logic [8:0] pa  [2];
   logic [8:0] pb  [2];
   int         last_grant;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, want, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_reqs();
      bus.req_valid = {pv[1], pv[0]};
      bus.req_op    = {pop[1], pop[0]};
      bus.req_a     = {pa[1], pa[0]};
      bus.req_b     = {pb[1], pb[0]};
   endtask

   task automatic set_req(input int i, input logic v, input logic [1:0] op,
                          input logic [8:0] a, input logic [8:0] b);
      pv[i] = v; pop[i] = op; pa[i] = a; pb[i] = b;
   endtask

   // kind 0: requester goes quiet; 1: new random job; 2: new random op-0 job
   task automatic new_job(input int i, input int kind);
      logic [1:0] op;
      op = (kind == 2) ? 2'd0 : 2'($urandom_range(3, 0));
      set_req(i, (kind != 0), op, 9'($urandom), 9'($urandom));
   endtask

   task automatic rand_sn();
      bus.sn_mul  = 1'($urandom);
      bus.sn_add  = 1'($urandom);
      bus.sn_smul = 1'($urandom);
   endtask

   // One full job from an IDLE cycle to the IDLE cycle after the response handshake.
   // mode: 0 random SN, 1 all ones, 2 all zeros, 3 toggling 1,0,1.. from first RUN cycle.
   task automatic run_job(input int mode, input int hold_low, input int refill);
      int         win;
      int         ones;
      logic [1:0] op;
      logic [8:0] a, b, want_d;
      logic       sbit;
      drive_reqs();
      #1;
      if (pv[0] && pv[1]) win = 1 - last_grant;
      else if (pv[1])     win = 1;
      else                win = 0;
      chk_eq("req_ready_grant", 32'(bus.req_ready), (win == 1) ? 32'd2 : 32'd1);
      chk_eq("busy_in_idle", 32'(bus.busy), 32'd0);
      op = pop[win]; a = pa[win]; b = pb[win];
      last_grant = win;
      next_cycle();
      new_job(win, refill);
      drive_reqs();
      rand_sn();
      #1;
      chk_eq("dp_input_1", 32'(bus.dp_input_1), 32'(a));
      chk_eq("dp_input_2", 32'(bus.dp_input_2), 32'(b));
      chk_eq("dp_op_sel", 32'(bus.dp_op_sel), 32'(op));
      chk_eq("busy_cycle1", 32'(bus.busy), 32'd1);
      chk_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (op == 2'd3) begin
         want_d = 9'd0;
      end else begin
         ones = 0;
         for (int c = 1; c <= S + RUNLEN; c++) begin
            rand_sn();
            bus.rsp_ready = 1'($urandom);
            if (c > S) begin
               case (mode)
                  1:       sbit = 1'b1;
                  2:       sbit = 1'b0;
                  3:       sbit = ((c - S - 1) % 2 == 0);
                  default: sbit = 1'($urandom);
               endcase
               if (op == 2'd0)      bus.sn_mul  = sbit;
               else if (op == 2'd1) bus.sn_add  = sbit;
               else                 bus.sn_smul = sbit;
               ones += int'(sbit);
            end
            #1;
            chk_eq("window_tick", 32'(bus.window_tick), (c == S + RUNLEN) ? 32'd1 : 32'd0);
            if (c % 64 == 1 || c == S + RUNLEN) begin
               chk_eq("req_ready_run", 32'(bus.req_ready), 32'd0);
               chk_eq("rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
            end
            next_cycle();
         end
         want_d = (ones == RUNLEN) ? 9'h1FF : 9'(ones / (RUNLEN / 512));
      end
      #1;
      chk_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk_eq("rsp_id", 32'(bus.rsp_id), 32'(win));
      chk_eq("rsp_data", 32'(bus.rsp_data), 32'(want_d));
      chk_eq("tick_in_resp", 32'(bus.window_tick), 32'd0);
      for (int k = 0; k < hold_low; k++) begin
         bus.rsp_ready = 1'b0;
         rand_sn();
         #1;
         chk_eq("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk_eq("hold_rsp_id", 32'(bus.rsp_id), 32'(win));
         chk_eq("hold_rsp_data", 32'(bus.rsp_data), 32'(want_d));
         chk_eq("hold_busy", 32'(bus.busy), 32'd1);
         chk_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
         chk_eq("hold_tick", 32'(bus.window_tick), 32'd0);
         next_cycle();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk_eq("hs_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      next_cycle();
      bus.rsp_ready = 1'($urandom);
      #1;
      chk_eq("busy_after_hs", 32'(bus.busy), 32'd0);
      chk_eq("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
      chk_eq("dp_hold_after_hs", 32'(bus.dp_input_1), 32'(a));
   endtask

   task automatic chk_all_zero(input string tag);
      chk_eq({tag, "_dp1"}, 32'(bus.dp_input_1), 32'd0);
      chk_eq({tag, "_dp2"}, 32'(bus.dp_input_2), 32'd0);
      chk_eq({tag, "_opsel"}, 32'(bus.dp_op_sel), 32'd0);
      chk_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk_eq({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
      chk_eq({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
      chk_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk_eq({tag, "_tick"}, 32'(bus.window_tick), 32'd0);
   endtask

   // Watchdog so the run always ends even if the bench itself stalls.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      bus.rsp_ready = 1'b0;
      rand_sn();
      set_req(0, 1'b0, 2'd0, 9'd0, 9'd0);
      set_req(1, 1'b0, 2'd0, 9'd0, 9'd0);
      drive_reqs();
      last_grant = 1;
      next_cycle();
      next_cycle();
      chk_all_zero("reset");
      chk_eq("reset_req_ready", 32'(bus.req_ready), 32'd0);
      rst_n = 1'b0;
      next_cycle();

      // Saturating multiply on requester 0.
      set_req(0, 1'b1, 2'd0, 9'h155, 9'h0AA);
      run_job(1, 0, 0);
      // Requester 1 add with toggling bits, then all zeros.
      set_req(1, 1'b1, 2'd1, 9'($urandom), 9'($urandom));
      run_job(3, 0, 0);
      set_req(1, 1'b1, 2'd1, 9'($urandom), 9'($urandom));
      run_job(2, 0, 0);
      // Both valid continuously: alternating grants.
      new_job(0, 2);
      new_job(1, 2);
      for (int j = 0; j < 4; j++) run_job(0, 0, 2);
      // Long response back-pressure with self-multiply.
      set_req(0, 1'b0, 2'd0, 9'd0, 9'd0);
      set_req(1, 1'b1, 2'd2, 9'($urandom), 9'($urandom));
      run_job(0, 20, 0);
      // Null op.
      set_req(0, 1'b1, 2'd3, 9'h1FF, 9'($urandom));
      run_job(0, 0, 0);
      // Random jobs.
      for (int j = 0; j < 12; j++) begin
         if (!pv[0] && !pv[1]) new_job(int'($urandom_range(1, 0)), 1);
         run_job(int'($urandom_range(3, 0)), int'($urandom_range(4, 0)),
                 int'($urandom_range(1, 0)));
      end

      // Reset in the middle of RUN drops the job and re-arms the pointer.
      set_req(0, 1'b0, 2'd0, 9'd0, 9'd0);
      set_req(1, 1'b1, 2'd0, 9'h0F0, 9'h00F);
      drive_reqs();
      #1;
      chk_eq("pre_reset_grant", 32'(bus.req_ready), 32'd2);
      next_cycle();
      for (int c = 1; c < S + 500; c++) begin
         rand_sn();
         next_cycle();
      end
      rst_n = 1'b1;
      next_cycle();
      rst_n = 1'b0;
      last_grant = 1;
      set_req(0, 1'b1, 2'd0, 9'($urandom), 9'($urandom));
      drive_reqs();
      #1;
      chk_all_zero("midrun_reset");
      run_job(0, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
